// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional MULDIV_FASTPATH_EN: trivial cases (div by zero, DIV overflow, zero mul operand) skip the iterations.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       MDcontrolE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] MDResult
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] spec_res_q, spec_res_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             spec_q, spec_d;

  // Operand decode at the request boundary
  logic             in_is_div, in_a_signed, in_b_signed;
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic             in_div0, in_ovf, in_mulz, in_spec;
  logic [WIDTH-1:0] in_spec_res;

  assign in_is_div   = MDcontrolE[2];
  assign in_a_signed = (MDcontrolE != 3'b011) && (MDcontrolE != 3'b101) && (MDcontrolE != 3'b111);
  assign in_b_signed = (MDcontrolE == 3'b000) || (MDcontrolE == 3'b001) ||
                       (MDcontrolE == 3'b100) || (MDcontrolE == 3'b110);
  assign in_neg_a    = in_a_signed && SrcAE[WIDTH-1];
  assign in_neg_b    = in_b_signed && SrcBE[WIDTH-1];
  assign in_mag_a    = in_neg_a ? (~SrcAE + 1'b1) : SrcAE;
  assign in_mag_b    = in_neg_b ? (~SrcBE + 1'b1) : SrcBE;

  assign in_div0 = in_is_div && (SrcBE == '0);
  assign in_ovf  = ((MDcontrolE == 3'b100) || (MDcontrolE == 3'b110)) &&
                   (SrcAE == MOST_NEG) && (SrcBE == '1);
  assign in_mulz = !in_is_div && ((SrcAE == '0) || (SrcBE == '0));
  assign in_spec = in_div0 || in_ovf || in_mulz;

  // REM/REMU have op bit 1 set; DIV/DIVU have it clear
  always_comb begin
    in_spec_res = '0;
    if (in_div0)
      in_spec_res = MDcontrolE[1] ? SrcAE : '1;
    else if (in_ovf)
      in_spec_res = MDcontrolE[1] ? '0 : SrcAE;
  end

  // Iteration datapath: {hi,lo} is the product accumulator or the remainder/quotient pair
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  // Sign fix-up of the magnitude result
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;

  assign prod_s = (neg_a_q ^ neg_b_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
  assign quo_s  = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
  assign rem_s  = neg_a_q ? (~hi_q + 1'b1) : hi_q;

  always_comb begin
    case (op_q)
      3'b000:                 fin_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_res = quo_s;
      default:                fin_res = rem_s;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    spec_res_d = spec_res_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    spec_d     = spec_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = CALC;
          op_d       = MDcontrolE;
          neg_a_d    = in_neg_a;
          neg_b_d    = in_neg_b;
          hi_d       = '0;
          lo_d       = in_is_div ? in_mag_a : in_mag_b;
          opnd_d     = in_is_div ? in_mag_b : in_mag_a;
          spec_d     = in_spec;
          spec_res_d = in_spec_res;
`ifdef MULDIV_FASTPATH_EN
          // Pre-load the counter so the next edge goes straight to the result
          cnt_d      = in_spec ? CW'(WIDTH) : '0;
`else
          cnt_d      = '0;
`endif
        end
      end
      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          result_d = spec_q ? spec_res_q : fin_res;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[2]) begin
            hi_d = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      spec_res_q <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      spec_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      spec_res_q <= spec_res_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      spec_q     <= spec_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign MDResult   = resp_valid ? result_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result values, response latency, stall, flush and reset aborts.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  MDcontrolE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] MDResult;

`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MDcontrolE (MDcontrolE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .MDResult   (MDResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  vec_t vecs[19];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  // Issue one op, count edges to resp_valid; optionally consume on the following edge.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                        input bit consume);
    int lat;
    bit seen;
    bit rdy_ok;
    bit zero_ok;
    lat = 0; seen = 1'b0; rdy_ok = 1'b1; zero_ok = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    MDcontrolE = op; SrcAE = a; SrcBE = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    SrcAE = $urandom; SrcBE = $urandom; MDcontrolE = 3'($urandom);
    while (!seen && lat < 100) begin
      if (req_ready) rdy_ok = 1'b0;
      if (MDResult !== 32'h0) zero_ok = 1'b0;
      @(posedge clk);
      lat++;
      #1;
      seen = resp_valid;
    end
    check({nm, " latency"}, 32'(lat), 32'(lat_exp));
    check({nm, " result"}, MDResult, exp);
    check({nm, " busy outputs"}, {30'h0, rdy_ok, zero_ok}, 32'h3);
    if (consume) begin
      @(posedge clk);
      #1;
      check({nm, " consumed"}, {30'h0, resp_valid, req_ready}, 32'h1);
    end
  endtask

  task automatic watch_quiet(input string nm);
    int hits;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) hits++;
    end
    check(nm, 32'(hits), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{"MUL 7*-3",          OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"MULHU ffff*ffff",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"MULH -1*-1",        OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{"MULHSU -1*ffff",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"DIV -7/2",          OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{"REM -7%2",          OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"DIVU 16/0",         OP_DIVU,   32'h10,       32'h0,        32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{"REMU 16%0",         OP_REMU,   32'h10,       32'h0,        32'h00000010, 1'b1};
    vecs[8]  = '{"DIV ovf",           OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[9]  = '{"REM ovf",           OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[10] = '{"DIVU 100/7",        OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[11] = '{"REMU 100%7",        OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[12] = '{"MUL 0*x",           OP_MUL,    32'h0,        32'h1234,     32'h0,        1'b1};
    vecs[13] = '{"DIV -7/0",          OP_DIV,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b1};
    vecs[14] = '{"REM 7%-2",          OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[15] = '{"MULHU 2^31*2",      OP_MULHU,  32'h80000000, 32'd2,        32'd1,        1'b0};
    vecs[16] = '{"MUL 2^16*2^16",     OP_MUL,    32'h00010000, 32'h00010000, 32'h0,        1'b0};
    vecs[17] = '{"MULH min*min",      OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[18] = '{"DIV 100/-7",        OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};

    // Reset state
    #1;
    check("in-reset outputs", {29'h0, resp_valid, req_ready, |MDResult}, 32'h2);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset outputs", {29'h0, resp_valid, req_ready, |MDResult}, 32'h2);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             (FAST && vecs[i].spec) ? 1 : 33, 1'b1);

    // Writeback stall: result held, no new accept
    resp_ready = 1'b0;
    run_op("stall MUL", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
    MDcontrolE = OP_DIVU; SrcAE = 32'd9; SrcBE = 32'd3; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall hold %0d", c), {resp_valid, req_ready, MDResult[29:0]},
            {1'b1, 1'b0, 30'h3FFFFFEB});
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall release", {30'h0, resp_valid, req_ready}, 32'h1);

    // Flush at CALC cycle 5
    @(negedge clk);
    MDcontrolE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush to idle", {30'h0, resp_valid, req_ready}, 32'h1);
    watch_quiet("flush no resp");
    run_op("after flush REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);

    // Flush wins over a simultaneous accept
    @(negedge clk);
    MDcontrolE = OP_MUL; SrcAE = 32'd3; SrcBE = 32'd5; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush beats accept", {30'h0, resp_valid, req_ready}, 32'h1);
    watch_quiet("flush-accept no resp");

    // Reset at CALC cycle 12
    @(negedge clk);
    MDcontrolE = OP_MUL; SrcAE = 32'd3; SrcBE = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset mid-CALC", {29'h0, resp_valid, req_ready, |MDResult}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("reset CALC no resp");
    run_op("after reset MUL", OP_MUL, 32'd3, 32'd5, 32'd15, 33, 1'b1);

    // Reset while a response is waiting in DONE
    resp_ready = 1'b0;
    run_op("pre-reset DIV", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset mid-DONE", {29'h0, resp_valid, req_ready, |MDResult}, 32'h2);
    resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("reset DONE no resp");
    run_op("after reset REM", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1  execute stage presents an operation.
REQ-005 SHALL have req_ready  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have MDcontrolE  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have SrcAE  input  WIDTH  operand A (multiplicand/dividend).
REQ-008 SHALL have SrcBE  input  WIDTH  operand B (multiplier/divisor).
REQ-009 SHALL have flush  input  1  synchronous abort of any in-flight operation.
REQ-010 SHALL have resp_valid  output  1  MDResult is valid.
REQ-011 SHALL have resp_ready  input  1  writeback consumes the result.
REQ-012 SHALL have MDResult  output  WIDTH  operation result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready, latching op and operands, moving to CALC.
REQ-015 SHALL ignore SrcAE/SrcBE/MDcontrolE changes after acceptance.
REQ-016 SHALL in CALC perform one shift-add (mul) or restoring shift-subtract (div) step per cycle on magnitudes, with a counter running WIDTH cycles, then enter DONE.
REQ-017 SHALL give resp_valid high from the (WIDTH+1)th rising edge after the accept edge (33 for WIDTH=32).
REQ-018 SHALL hold resp_valid and MDResult stable in DONE until resp_valid&&resp_ready, then return to IDLE next edge.
REQ-019 SHALL not accept a new request in the cycle a response is consumed (req_ready low in DONE).
REQ-020 SHALL return low WIDTH bits of product for MUL; high WIDTH bits of 2*WIDTH product for MULH (s×s), MULHSU (s×u), MULHU (u×u).
REQ-021 SHALL return truncated-toward-zero quotient for DIV/DIVU; remainder with dividend's sign for REM/REMU.
REQ-022 SHALL on divisor 0 return all-ones for DIV/DIVU and the dividend for REM/REMU.
REQ-023 SHALL on DIV overflow (A=most-negative, B=-1) return A for DIV and 0 for REM.
REQ-024 SHALL on flush (any state) go to IDLE next edge, drop resp_valid, discard result; flush beats a simultaneous accept.
REQ-025 SHALL drive MDResult 0 whenever resp_valid is low.

Reset
REQ-026 SHALL on rst_n low immediately force IDLE, counter 0, resp_valid 0, MDResult 0, req_ready 1 after deassertion.
REQ-027 SHALL abort any in-flight operation on reset mid-CALC or mid-DONE with no response emitted.

Configuration
REQ-028 SHALL use macro MULDIV_FASTPATH_EN.
REQ-029 SHALL with MULDIV_FASTPATH_EN defined detect divisor-zero, DIV overflow, and either multiply operand zero at accept and enter DONE directly, resp_valid on the 1st edge after accept.
REQ-030 SHALL without MULDIV_FASTPATH_EN process those cases through full CALC (WIDTH+1 edge latency), same results.

Verification
REQ-031 SHALL cover MUL A=7, B=-3 -> MDResult 0xFFFFFFEB, resp_valid at edge 33 after accept.
REQ-032 SHALL cover MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-033 SHALL cover DIV A=-7, B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU A=0x10, B=0 -> 0xFFFFFFFF; REMU -> 0x10.
REQ-034 SHALL cover DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, REM -> 0; with MULDIV_FASTPATH_EN resp_valid at edge 1.
REQ-035 SHALL cover resp_ready held low 10 cycles after DONE -> resp_valid/MDResult stable, req_ready 0; release -> IDLE next edge.
REQ-036 SHALL cover flush at CALC cycle 5 and rst_n low at CALC cycle 12 -> IDLE, no resp_valid pulse, next op correct.
